// File: rtl/image_cache_read_arb_pkg.sv
// Shared types and constants for the image cache read arbiter.
// Holds the requester tag type, the request bundle and the response latency.
package pkg_imageCacheArb;

  localparam int NUM_REQ_MAX = 8;
  localparam int COORD_W_MAX = 16;
  localparam int RSP_LATENCY = 2;

  typedef logic [2:0] tag_t;

  typedef struct packed {
    logic [COORD_W_MAX-1:0] x;
    logic [COORD_W_MAX-1:0] y;
    logic                   lock;
  } arb_req_t;

  // Round-robin successor of the winner, wrapping at n.
  function automatic tag_t next_ptr(tag_t w, int n);
    if (int'(w) >= n - 1) return '0;
    return w + tag_t'(1);
  endfunction

endpackage

// File: rtl/image_cache_read_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Ports: req (request vector), ptr (start index), grant (one-hot), idx (winner).
module rr_pick
  import pkg_imageCacheArb::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  tag_t               ptr,
  output logic [NUM_REQ-1:0] grant,
  output tag_t               idx
);

  logic [3:0] d;
  logic [3:0] best_d;
  logic       any;

  // Pick the valid requester with the smallest forward distance from ptr.
  always_comb begin
    d      = '0;
    best_d = 4'hf;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (4'(i) >= {1'b0, ptr})
        d = 4'(i) - {1'b0, ptr};
      else
        d = 4'(i) + 4'(NUM_REQ) - {1'b0, ptr};
      if (req[i] && d < best_d) begin
        best_d = d;
        idx    = tag_t'(i);
      end
    end
  end

  assign any = |req;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant[i] = any && (idx == tag_t'(i));
  end

endmodule

// File: rtl/image_cache_read_arb.sv
// Round-robin read-port arbiter for the image cache with bounded burst lock.
// Ports: clk, rst (sync, active-high); req_valid/req_lock/req_x/req_y in,
// req_ready out (one-hot grant); cache_raddrX/Y out, cache_q in;
// rsp_valid (one-hot) and rsp_data out, fixed 2-cycle latency from handshake.
// Legal ranges: NUM_REQ 1..8, MAX_BURST 1..255, X/Y_WIDTH up to 16.
module image_cache_read_arb
  import pkg_imageCacheArb::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int X_WIDTH   = 9,
  parameter int Y_WIDTH   = 9,
  parameter int WORD_SIZE = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [NUM_REQ*X_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [X_WIDTH-1:0]     cache_raddrX,
  output logic [Y_WIDTH-1:0]     cache_raddrY,
  input  logic [WORD_SIZE-1:0]   cache_q,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [WORD_SIZE-1:0]   rsp_data
);

  arb_req_t reqs [NUM_REQ];
  arb_req_t win_req;

  logic [NUM_REQ-1:0] rr_grant;
  tag_t               rr_idx;

  tag_t               ptr;
  logic               lock_vld;
  logic [NUM_REQ-1:0] lock_oh;
  tag_t               lock_idx;
  logic [7:0]         burst;

  logic               own_hit;
  logic               own_ok;
  logic [NUM_REQ-1:0] grant;
  tag_t               win;
  logic               hs;
  logic               was_own;
  logic [7:0]         nxt_burst;
  logic               burst_end;

  tag_t                   tag_q [RSP_LATENCY];
  logic [RSP_LATENCY-1:0] vld_q;
  logic [NUM_REQ-1:0]     rsp_oh;

  logic unused_req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign reqs[g] = '{
      x:    COORD_W_MAX'(req_x[g*X_WIDTH +: X_WIDTH]),
      y:    COORD_W_MAX'(req_y[g*Y_WIDTH +: Y_WIDTH]),
      lock: req_lock[g]
    };
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // A live lock owner pre-empts the round-robin scan.
  assign own_hit = |(lock_oh & req_valid);
  assign own_ok  = lock_vld && own_hit
                && (burst < 8'(MAX_BURST));
  assign grant   = own_ok ? lock_oh : rr_grant;
  assign win     = own_ok ? lock_idx : rr_idx;

  assign req_ready = rst ? '0 : grant;
  assign hs        = |req_ready;

  always_comb begin
    win_req = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) win_req = reqs[i];
  end

  assign unused_req = ^win_req;

  assign was_own   = lock_vld && |(lock_oh & grant);
  assign nxt_burst = was_own ? burst + 8'd1 : 8'd1;
  // Hitting the burst cap releases the lock so others cannot starve.
  assign burst_end = nxt_burst >= 8'(MAX_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lock_vld <= 1'b0;
      lock_oh  <= '0;
      lock_idx <= '0;
      burst    <= '0;
    end else if (hs) begin
      ptr <= next_ptr(win, NUM_REQ);
      if (win_req.lock && !burst_end) begin
        lock_vld <= 1'b1;
        lock_oh  <= grant;
        lock_idx <= win;
        burst    <= nxt_burst;
      end else begin
        lock_vld <= 1'b0;
        lock_oh  <= '0;
        burst    <= '0;
      end
    end else if (lock_vld && !own_hit) begin
      lock_vld <= 1'b0;
      lock_oh  <= '0;
      burst    <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_raddrX <= '0;
      cache_raddrY <= '0;
    end else if (hs) begin
      cache_raddrX <= win_req.x[X_WIDTH-1:0];
      cache_raddrY <= win_req.y[Y_WIDTH-1:0];
    end
  end

  // Tag pipeline tracks which requester owns each in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RSP_LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[RSP_LATENCY-2:0], hs};
      tag_q[0] <= win;
      for (int i = 1; i < RSP_LATENCY; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    rsp_oh = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_oh[i] = vld_q[RSP_LATENCY-1]
               && (tag_q[RSP_LATENCY-1] == tag_t'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_oh;
      if (vld_q[RSP_LATENCY-1])
        rsp_data <= cache_q;
    end
  end

endmodule

// File: tb/tb_image_cache_read_arb.sv
// Self-checking bench for image_cache_read_arb with a behavioural model.
// Covers directed scenarios, randomized traffic and a single-requester build.
module tb_image_cache_read_arb;

  localparam int NR = 4;
  localparam int XW = 9;
  localparam int YW = 9;
  localparam int WS = 8;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_lock  = '0;
  logic [NR*XW-1:0] req_x     = '0;
  logic [NR*YW-1:0] req_y     = '0;
  logic [NR-1:0]    req_ready;
  logic [XW-1:0]    cache_raddrX;
  logic [YW-1:0]    cache_raddrY;
  logic [WS-1:0]    cache_q = '0;
  logic [NR-1:0]    rsp_valid;
  logic [WS-1:0]    rsp_data;

  logic          v1 = 1'b0;
  logic          l1 = 1'b0;
  logic [XW-1:0] x1 = '0;
  logic [YW-1:0] y1 = '0;
  logic          ready1;
  logic [XW-1:0] raddrX1;
  logic [YW-1:0] raddrY1;
  logic [WS-1:0] q1 = '0;
  logic          rspv1;
  logic [WS-1:0] rspd1;

  image_cache_read_arb #(
    .NUM_REQ(NR), .X_WIDTH(XW), .Y_WIDTH(YW),
    .WORD_SIZE(WS), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready),
    .cache_raddrX(cache_raddrX), .cache_raddrY(cache_raddrY),
    .cache_q(cache_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  image_cache_read_arb #(
    .NUM_REQ(1), .X_WIDTH(XW), .Y_WIDTH(YW),
    .WORD_SIZE(WS), .MAX_BURST(MB)
  ) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_lock(l1),
    .req_x(x1), .req_y(y1),
    .req_ready(ready1),
    .cache_raddrX(raddrX1), .cache_raddrY(raddrY1),
    .cache_q(q1),
    .rsp_valid(rspv1), .rsp_data(rspd1)
  );

  function automatic logic [7:0] pix(logic [8:0] x, logic [8:0] y);
    return 8'(int'(x) + 16 * int'(y));
  endfunction

  // Cache contents mem[y][x] = x + 16*y, one-cycle registered read.
  always @(posedge clk) begin
    cache_q <= pix(cache_raddrX, cache_raddrY);
    q1      <= pix(raddrX1, raddrY1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    int         rq;
    logic [7:0] d;
  } pend_t;

  pend_t      pend[$];
  int         m_ptr = 0;
  int         m_own = -1;
  int         m_cnt = 0;
  logic [8:0] m_ax  = '0;
  logic [8:0] m_ay  = '0;

  // One cycle: check registered outputs, drive inputs, check grant, advance model.
  task automatic step(input logic r, input logic [NR-1:0] v,
                      input logic [NR-1:0] lk,
                      input logic [NR*XW-1:0] xs,
                      input logic [NR*YW-1:0] ys, output int got);
    logic [NR-1:0] ev;
    logic [7:0]    ed;
    logic [NR-1:0] er;
    int            w;
    ev = '0;
    ed = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = NR'(1) << pend[0].rq;
      ed = pend[0].d;
      void'(pend.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != '0) chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("raddr", {14'd0, cache_raddrY, cache_raddrX},
        {14'd0, m_ay, m_ax});
    rst       = r;
    req_valid = v;
    req_lock  = lk;
    req_x     = xs;
    req_y     = ys;
    #1;
    w = -1;
    if (!r) begin
      if (m_own >= 0 && v[m_own] && m_cnt < MB) w = m_own;
      else
        for (int k = 0; k < NR; k++)
          if (w < 0 && v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
    end
    er = (w < 0) ? '0 : NR'(1) << w;
    chk("req_ready", 32'(req_ready), 32'(er));
    got = -1;
    for (int k = 0; k < NR; k++) if (req_ready[k]) got = k;
    if (r) begin
      m_ptr = 0; m_own = -1; m_cnt = 0;
      m_ax = '0; m_ay = '0;
      pend.delete();
    end else begin
      if (m_own >= 0 && !v[m_own]) begin
        m_own = -1; m_cnt = 0;
      end
      if (w >= 0) begin
        m_ax = xs[w*XW +: XW];
        m_ay = ys[w*YW +: YW];
        pend.push_back('{cyc + 3, w, pix(m_ax, m_ay)});
        m_ptr = (w + 1) % NR;
        if (lk[w]) begin
          if (m_own == w) m_cnt++;
          else begin m_own = w; m_cnt = 1; end
          if (m_cnt >= MB) begin m_own = -1; m_cnt = 0; end
        end else begin
          m_own = -1; m_cnt = 0;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rstep(input logic r, input logic [NR-1:0] v,
                       input logic [NR-1:0] lk, output int got);
    logic [NR*XW-1:0] xs;
    logic [NR*YW-1:0] ys;
    for (int k = 0; k < NR; k++) begin
      xs[k*XW +: XW] = XW'($urandom);
      ys[k*YW +: YW] = YW'($urandom);
    end
    step(r, v, lk, xs, ys, got);
  endtask

  initial begin
    int               g;
    logic [NR-1:0]    seen;
    logic [NR*XW-1:0] xs;
    logic [NR*YW-1:0] ys;
    logic [NR-1:0]    v;
    logic [NR-1:0]    lk;

    rst       = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_raddr", {14'd0, cache_raddrY, cache_raddrX}, 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);

    // Single read from requester 1 at (y=2, x=3).
    xs = '0;
    ys = '0;
    xs[1*XW +: XW] = 9'd3;
    ys[1*YW +: YW] = 9'd2;
    step(1'b0, 4'b0010, 4'b0000, xs, ys, g);
    chk("t1_grant", g, 1);
    chk("t1_raddr", {14'd0, cache_raddrY, cache_raddrX},
        {14'd0, 9'd2, 9'd3});
    rstep(1'b0, 4'b0000, 4'b0000, g);
    rstep(1'b0, 4'b0000, 4'b0000, g);
    chk("t1_rsp", {20'd0, rsp_valid, rsp_data}, {20'd0, 4'b0010, 8'h23});
    repeat (2) rstep(1'b0, 4'b0000, 4'b0000, g);

    // All valid, no lock: plain round robin.
    rstep(1'b1, 4'b1111, 4'b0000, g);
    chk("t2_rst_ready", g, -1);
    for (int i = 0; i < 6; i++) begin
      rstep(1'b0, 4'b1111, 4'b0000, g);
      chk("t2_order", g, i % 4);
    end

    // Requester 2 locked from pointer 2: burst of MB, then 3, then 0.
    for (int i = 0; i < MB + 2; i++) begin
      rstep(1'b0, 4'b1111, 4'b0100, g);
      chk("t3_order", g, (i < MB) ? 2 : ((i == MB) ? 3 : 0));
    end
    repeat (4) rstep(1'b0, 4'b0000, 4'b0000, g);

    // Reset right after a handshake kills the pending response.
    rstep(1'b0, 4'b0001, 4'b0000, g);
    chk("t4_hs", g, 0);
    rstep(1'b1, 4'b0001, 4'b0000, g);
    seen = rsp_valid;
    rstep(1'b0, 4'b1010, 4'b0000, g);
    seen |= rsp_valid;
    chk("t4_first", g, 1);
    rstep(1'b0, 4'b0000, 4'b0000, g);
    seen |= rsp_valid;
    chk("t4_no_rsp", 32'(seen), 32'd0);
    repeat (3) rstep(1'b0, 4'b0000, 4'b0000, g);

    // Lock owner drops valid: other requester wins the same cycle.
    rstep(1'b0, 4'b0001, 4'b0001, g);
    chk("t5_lock", g, 0);
    rstep(1'b0, 4'b0101, 4'b0001, g);
    chk("t5_hold", g, 0);
    rstep(1'b0, 4'b0100, 4'b0000, g);
    chk("t5_drop", g, 2);
    rstep(1'b0, 4'b0111, 4'b0000, g);
    chk("t5_rr", g, 0);

    // Randomized traffic with hot phases that exercise the burst cap.
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 < 100) begin
        v  = 4'b1111;
        lk = 4'b1111;
      end else begin
        v  = 4'($urandom) | 4'($urandom);
        lk = 4'($urandom) & 4'($urandom);
      end
      rstep(($urandom_range(0, 199) == 0), v, lk, g);
    end
    repeat (4) rstep(1'b0, 4'b0000, 4'b0000, g);

    // Single-requester build: back-to-back row reads.
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 14; i++) begin
      chk("t6_rsp_valid", 32'(rspv1), 32'(i >= 3 && i < 13));
      if (i >= 3 && i < 13)
        chk("t6_rsp_data", 32'(rspd1), 32'(8'h50 + 8'(i - 3)));
      v1 = (i < 10);
      l1 = (i % 3 == 0);
      x1 = XW'(i);
      y1 = 9'd5;
      #1;
      chk("t6_ready", 32'(ready1), 32'(v1));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_cache_read_arb.md
Name: image_cache_read_arb

Overview:
- Shares the single read port of the image cache between NUM_REQ requesters, e.g. window scanners and feature evaluators.
- Each requester presents a (Y, X) pixel coordinate with a valid/ready handshake.
- Arbitration is round-robin, with an optional bounded burst lock for row scans.
- Read data returns to the issuing requester with a fixed latency and a per-requester valid strobe.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 1..8.
- X_WIDTH, 9: width of the X coordinate.
- Y_WIDTH, 9: width of the Y coordinate.
- WORD_SIZE, 8: width of a cache data word.
- MAX_BURST, 8: maximum consecutive locked grants to one requester; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_lock  in  NUM_REQ  requester asks to keep the grant on its next request.
- req_x  in  NUM_REQ*X_WIDTH  X coordinates; requester i uses bits [i*X_WIDTH +: X_WIDTH].
- req_y  in  NUM_REQ*Y_WIDTH  Y coordinates, packed the same way.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when valid and ready are both 1.
- cache_raddrX  out  X_WIDTH  registered X coordinate to the cache read port.
- cache_raddrY  out  Y_WIDTH  registered Y coordinate to the cache read port.
- cache_q  in  WORD_SIZE  cache read data, valid one cycle after the address is presented.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  WORD_SIZE  response word, broadcast to all requesters; qualified by rsp_valid.

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, cache_raddrX=0, cache_raddrY=0, RR pointer=0, lock owner=none, burst count=0, pipeline tags invalid.
- req_ready=0 in any cycle where rst=1.
- Grant rule (combinational, cycle t):
  - If a lock owner exists, its req_valid=1, and burst count<MAX_BURST, the owner wins.
  - Otherwise, the first valid requester scanning from the RR pointer upward (with wrap) wins.
  - req_ready is one-hot on the winner, or all-zero if no request is valid.
  - At most one handshake per cycle; throughput is 1 read per cycle.
- Pointer and lock update, on each handshake by winner w:
  - Pointer becomes (w+1) mod NUM_REQ.
  - If req_lock[w]=1: lock owner becomes w; burst count increments if w was already the owner, otherwise it is set to 1.
  - If req_lock[w]=0: lock is cleared and burst count becomes 0.
  - When burst count reaches MAX_BURST, the lock is cleared and normal round-robin resumes from w+1. This is the starvation guard.
  - If the lock owner drops req_valid, the lock is cleared and normal round-robin applies in that same cycle.
- Pipeline:
  - Handshake at edge t: cache_raddrX/Y are loaded with the winner's coordinate and tag stage 1 records w.
  - At edge t+1: the cache registers the address; tag stage 2 records w.
  - At edge t+2: rsp_data<=cache_q and rsp_valid<=onehot(w).
  - rsp_valid is therefore high in the cycle after edge t+2, i.e. fixed latency 2 from the handshake edge.
  - When there is no handshake, cache_raddrX/Y hold their value and the tag is invalid.
- Coordinates pass through unchanged with no range check. Linear address computation belongs to the cache.
- Reset mid-operation: all in-flight tags are discarded and rsp_valid stays 0 for every pending read. The first grant after reset follows pointer=0.
- With NUM_REQ=1, requester 0 is granted whenever it is valid; lock logic is still legal but has no effect.
- Read-during-write to the same address returns undefined data (mixed-port don't-care); requesters must avoid it.

Decomposition:
- Package pkg_imageCacheArb holds:
  - NUM_REQ_MAX=8;
  - typedef tag_t, logic [2:0];
  - typedef struct arb_req_t {x, y, lock};
  - the latency constant RSP_LATENCY=2.
- Sub-module rr_pick: purely combinational. Inputs are the request vector and the pointer; outputs are the one-hot grant and the encoded winner index.
- Pointer, lock and burst state, the address registers and the tag pipeline stay in the top-level block.

Test Plan:
1. Cache preloaded with mem[y][x]=x+16*y. Req1 issues y=2, x=3 -> req_ready[1]=1 in the same cycle; cache_raddrY/X=2/3 after the next edge; rsp_valid=4'b0010 with rsp_data=0x23 two edges after the handshake.
2. All four valid continuously, locks off -> grant order 0,1,2,3,0,1; one response per cycle in the same order; data matches the issued coordinates.
3. All valid, req_lock[2]=1 held, pointer starting at 2 -> requester 2 granted 8 consecutive cycles (MAX_BURST=8), then requester 3, then 0.
4. Handshake from req0 at t, rst high at t+1 for one cycle -> rsp_valid stays 0 throughout; after reset, req3 and req1 valid -> req1 granted first (pointer=0).
5. Req0 locked, then req_valid[0] dropped for one cycle while req2 is valid -> req2 is granted in that cycle and the lock is cleared.
6. NUM_REQ=1 build, 10 back-to-back reads along x=0..9, y=5 -> 10 consecutive rsp_valid pulses with data 0x50..0x59.
